// File: rtl/general_purpose_register_file_mp.sv
// General purpose register file for the dual-issue decode stage.
// Holds REGISTER_COUNT registers of DATA_WIDTH bits with READ_PORTS combinational
// read ports, two prioritised write ports (port 1 wins on an address clash),
// optional same-cycle write-to-read forwarding and a per-register busy scoreboard.
//
// Ports:
//   system_clock    - clock, all state updates on the rising edge
//   system_reset    - synchronous active-high clear of registers and busy bits
//   write_enable_N  - write port N valid (N = 0, 1; port 1 has priority)
//   write_address_N - write port N target register
//   write_data_N    - write port N data
//   issue_enable    - mark issue_address busy (new producer outstanding)
//   issue_address   - destination register of the newly issued instruction
//   read_address    - flattened read addresses, port k at [k*ADDRESS_SIZE +: ADDRESS_SIZE]
//   read_data       - flattened read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   read_busy       - busy bit seen by each read port (cleared when data is forwarded)
//   busy_vector     - raw scoreboard state, one bit per register
module general_purpose_register_file_mp #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REGISTER_COUNT = 32,
  parameter int unsigned READ_PORTS     = 2,
  parameter bit          BYPASS_ENABLE  = 1'b1,
  parameter bit          ZERO_HARDWIRED = 1'b1,
  localparam int unsigned ADDRESS_SIZE  = $clog2(REGISTER_COUNT)
) (
  input  logic                               system_clock,
  input  logic                               system_reset,
  input  logic                               write_enable_0,
  input  logic [ADDRESS_SIZE-1:0]            write_address_0,
  input  logic [DATA_WIDTH-1:0]              write_data_0,
  input  logic                               write_enable_1,
  input  logic [ADDRESS_SIZE-1:0]            write_address_1,
  input  logic [DATA_WIDTH-1:0]              write_data_1,
  input  logic                               issue_enable,
  input  logic [ADDRESS_SIZE-1:0]            issue_address,
  input  logic [READ_PORTS*ADDRESS_SIZE-1:0] read_address,
  output logic [READ_PORTS*DATA_WIDTH-1:0]   read_data,
  output logic [READ_PORTS-1:0]              read_busy,
  output logic [REGISTER_COUNT-1:0]          busy_vector
);

  logic [DATA_WIDTH-1:0]     regs [REGISTER_COUNT];
  logic [REGISTER_COUNT-1:0] busy;
  logic [REGISTER_COUNT-1:0] busy_next;
  logic [REGISTER_COUNT-1:0] write_hit_0;
  logic [REGISTER_COUNT-1:0] write_hit_1;
  logic [REGISTER_COUNT-1:0] issue_hit;

  // One-hot decode of write and issue targets; register 0 masked when hardwired.
  always_comb begin
    write_hit_0 = '0;
    write_hit_1 = '0;
    issue_hit   = '0;
    if (write_enable_0) write_hit_0[write_address_0] = 1'b1;
    if (write_enable_1) write_hit_1[write_address_1] = 1'b1;
    if (issue_enable)   issue_hit[issue_address]     = 1'b1;
    if (ZERO_HARDWIRED) begin
      write_hit_0[0] = 1'b0;
      write_hit_1[0] = 1'b0;
      issue_hit[0]   = 1'b0;
    end
  end

  // Issue sets after writeback clears, so a same-cycle issue leaves the register busy.
  always_comb begin
    busy_next = (busy & ~(write_hit_0 | write_hit_1)) | issue_hit;
  end

  // Register storage and scoreboard.
  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      for (int r = 0; r < int'(REGISTER_COUNT); r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
    end else begin
      for (int r = 0; r < int'(REGISTER_COUNT); r++) begin
        if (write_hit_1[r]) begin
          regs[r] <= write_data_1;
        end else if (write_hit_0[r]) begin
          regs[r] <= write_data_0;
        end
      end
      busy <= busy_next;
    end
  end

  assign busy_vector = busy;

  // Read ports: hardwired zero first, then forwarding (port 1 over port 0), then storage.
  for (genvar k = 0; k < int'(READ_PORTS); k++) begin : g_read
    logic [ADDRESS_SIZE-1:0] addr;
    logic                    fwd_0;
    logic                    fwd_1;
    logic                    zero_sel;
    logic [DATA_WIDTH-1:0]   data;
    logic                    busy_bit;

    assign addr     = read_address[k*ADDRESS_SIZE +: ADDRESS_SIZE];
    assign fwd_1    = BYPASS_ENABLE && !system_reset && write_enable_1 && (write_address_1 == addr);
    assign fwd_0    = BYPASS_ENABLE && !system_reset && write_enable_0 && (write_address_0 == addr);
    assign zero_sel = ZERO_HARDWIRED && (addr == '0);

    always_comb begin
      data     = regs[addr];
      busy_bit = busy[addr];
      if (zero_sel) begin
        data     = '0;
        busy_bit = 1'b0;
      end else if (fwd_1) begin
        data     = write_data_1;
        busy_bit = 1'b0;
      end else if (fwd_0) begin
        data     = write_data_0;
        busy_bit = 1'b0;
      end
    end

    assign read_data[k*DATA_WIDTH +: DATA_WIDTH] = data;
    assign read_busy[k]                          = busy_bit;
  end

endmodule

// File: tb/tb_general_purpose_register_file_mp.sv
// Scoreboard bench for general_purpose_register_file_mp.
// Two instances share stimulus: dut_a (bypass on, r0 hardwired) and
// dut_b (bypass off, r0 ordinary). Expected outputs come from array models.
module tb_general_purpose_register_file_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned RC = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned RP = 2;

  logic clk;
  logic rst;
  logic we0, we1, ie;
  logic [AW-1:0] wa0, wa1, ia;
  logic [DW-1:0] wd0, wd1;
  logic [RP*AW-1:0] raddr;
  logic [RP*DW-1:0] rd_a, rd_b;
  logic [RP-1:0]    rb_a, rb_b;
  logic [RC-1:0]    bv_a, bv_b;

  general_purpose_register_file_mp #(
    .DATA_WIDTH(DW), .REGISTER_COUNT(RC), .READ_PORTS(RP),
    .BYPASS_ENABLE(1'b1), .ZERO_HARDWIRED(1'b1)
  ) dut_a (
    .system_clock(clk), .system_reset(rst),
    .write_enable_0(we0), .write_address_0(wa0), .write_data_0(wd0),
    .write_enable_1(we1), .write_address_1(wa1), .write_data_1(wd1),
    .issue_enable(ie), .issue_address(ia),
    .read_address(raddr), .read_data(rd_a), .read_busy(rb_a), .busy_vector(bv_a)
  );

  general_purpose_register_file_mp #(
    .DATA_WIDTH(DW), .REGISTER_COUNT(RC), .READ_PORTS(RP),
    .BYPASS_ENABLE(1'b0), .ZERO_HARDWIRED(1'b0)
  ) dut_b (
    .system_clock(clk), .system_reset(rst),
    .write_enable_0(we0), .write_address_0(wa0), .write_data_0(wd0),
    .write_enable_1(we1), .write_address_1(wa1), .write_data_1(wd1),
    .issue_enable(ie), .issue_address(ia),
    .read_address(raddr), .read_data(rd_b), .read_busy(rb_b), .busy_vector(bv_b)
  );

  // Clock starts high so inputs driven after a rising edge are sampled on the next falling edge.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [63:0] rd_a;
    logic [63:0] rd_b;
    logic [1:0]  rb_a;
    logic [1:0]  rb_b;
    logic [31:0] bv_a;
    logic [31:0] bv_b;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state: A = bypass/zero-hardwired, B = plain storage.
  logic [DW-1:0] mem_a [RC];
  logic [DW-1:0] mem_b [RC];
  logic [RC-1:0] busy_a;
  logic [RC-1:0] busy_b;

  function automatic void model_read(input bit cfg_b, input int a,
                                     output logic [DW-1:0] d, output logic b);
    bit byp;
    bit zero;
    byp  = !cfg_b;
    zero = !cfg_b;
    if (zero && a == 0) begin
      d = '0; b = 1'b0;
    end else if (byp && !rst && we1 && int'(wa1) == a) begin
      d = wd1; b = 1'b0;
    end else if (byp && !rst && we0 && int'(wa0) == a) begin
      d = wd0; b = 1'b0;
    end else begin
      d = cfg_b ? mem_b[a] : mem_a[a];
      b = cfg_b ? busy_b[a] : busy_a[a];
    end
  endfunction

  // Applies the current inputs to the model at the clock edge.
  function automatic void model_update();
    if (rst) begin
      for (int i = 0; i < int'(RC); i++) begin
        mem_a[i] = '0;
        mem_b[i] = '0;
      end
      busy_a = '0;
      busy_b = '0;
    end else begin
      if (we0) begin
        if (wa0 != '0) mem_a[wa0] = wd0;
        mem_b[wa0] = wd0;
        busy_a[wa0] = 1'b0;
        busy_b[wa0] = 1'b0;
      end
      if (we1) begin
        if (wa1 != '0) mem_a[wa1] = wd1;
        mem_b[wa1] = wd1;
        busy_a[wa1] = 1'b0;
        busy_b[wa1] = 1'b0;
      end
      if (ie) begin
        if (ia != '0) busy_a[ia] = 1'b1;
        busy_b[ia] = 1'b1;
      end
    end
  endfunction

  task automatic step(input logic r,
                      input logic e0, input int a0, input logic [DW-1:0] d0,
                      input logic e1, input int a1, input logic [DW-1:0] d1,
                      input logic e_i, input int a_i,
                      input int ra0, input int ra1);
    exp_t e;
    logic [DW-1:0] d;
    logic b;
    int ra[2];
    rst = r;
    we0 = e0; wa0 = AW'(a0); wd0 = d0;
    we1 = e1; wa1 = AW'(a1); wd1 = d1;
    ie  = e_i; ia = AW'(a_i);
    raddr = {AW'(ra1), AW'(ra0)};
    ra[0] = ra0;
    ra[1] = ra1;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      model_read(1'b0, ra[k], d, b);
      e.rd_a[k*32 +: 32] = d;
      e.rb_a[k] = b;
      model_read(1'b1, ra[k], d, b);
      e.rd_b[k*32 +: 32] = d;
      e.rb_b[k] = b;
    end
    e.bv_a = busy_a;
    e.bv_b = busy_b;
    q.push_back(e);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(input int ra0, input int ra1);
    step(1'b0, 1'b0, 0, '0, 1'b0, 0, '0, 1'b0, 0, ra0, ra1);
  endtask

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
    end
  endfunction

  // Monitor: every falling edge with a pending expectation, compare all outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("read_data_a", 64'(rd_a), e.rd_a);
        check("read_data_b", 64'(rd_b), e.rd_b);
        check("read_busy_a", 64'(rb_a), 64'(e.rb_a));
        check("read_busy_b", 64'(rb_b), 64'(e.rb_b));
        check("busy_vector_a", 64'(bv_a), 64'(e.bv_a));
        check("busy_vector_b", 64'(bv_b), 64'(e.bv_b));
      end
    end
  end

  function automatic int rnd_addr();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 7));
    return int'($urandom_range(0, RC - 1));
  endfunction

  initial begin
    rst = 1'b1;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    ie = 1'b0; ia = '0;
    raddr = '0;
    // Initial reset cycle: storage is unknown until the first edge, so nothing is expected yet.
    @(posedge clk);
    model_update();
    #1;

    // Reset state through the read path.
    idle(5, 31);
    // Write with same-cycle read (forwarded on A, old value on B), then stored.
    step(1'b0, 1'b1, 7, 32'hDEADBEEF, 1'b0, 0, '0, 1'b0, 0, 7, 7);
    idle(7, 7);
    // Same-address write on both ports: port 1 wins.
    step(1'b0, 1'b1, 3, 32'h11, 1'b1, 3, 32'h22, 1'b0, 0, 3, 3);
    idle(3, 3);
    // Write and issue to register 0.
    step(1'b0, 1'b1, 0, 32'h55, 1'b0, 0, '0, 1'b1, 0, 0, 0);
    idle(0, 0);
    // Scoreboard: issue, writeback clears, issue beats same-cycle writeback.
    step(1'b0, 1'b0, 0, '0, 1'b0, 0, '0, 1'b1, 9, 9, 9);
    idle(9, 9);
    step(1'b0, 1'b1, 9, 32'hA5, 1'b0, 0, '0, 1'b0, 0, 9, 9);
    idle(9, 9);
    step(1'b0, 1'b0, 0, '0, 1'b1, 9, 32'h77, 1'b1, 9, 9, 3);
    idle(9, 9);
    // Reset discards a concurrent write and clears the scoreboard.
    step(1'b0, 1'b1, 4, 32'h1234, 1'b0, 0, '0, 1'b1, 4, 4, 9);
    step(1'b1, 1'b1, 4, 32'hFFFF, 1'b0, 0, '0, 1'b0, 0, 4, 9);
    idle(4, 9);

    // Randomised traffic with a bias toward low addresses for collisions.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 63) == 0,
           1'($urandom_range(0, 1)), rnd_addr(), $urandom,
           1'($urandom_range(0, 1)), rnd_addr(), $urandom,
           1'($urandom_range(0, 2) == 0), rnd_addr(),
           rnd_addr(), rnd_addr());
    end

    idle(0, 1);
    repeat (2) @(posedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/general_purpose_register_file_mp.md
Name: general_purpose_register_file_mp

Overview:
Parametrised successor to the 2-read/1-write general purpose register file, for the dual-issue pipeline.
- Configurable data width, register count and read-port count.
- Two write ports with fixed priority and optional same-cycle write-to-read bypass.
- Per-register busy scoreboard for decode-stage hazard detection.
- Synchronous clearing reset.
Sits in decode: read ports feed operand muxes, write ports driven from writeback, issue port from the issue stage.

Parameters:
DATA_WIDTH, 32, bits per register
REGISTER_COUNT, 32, number of architectural registers (power of two, >=2)
ADDRESS_SIZE, $clog2(REGISTER_COUNT), register address width (derived, not overridden)
READ_PORTS, 2, number of combinational read ports (1..4)
BYPASS_ENABLE, 1, 1 = read returns same-cycle write data; 0 = read returns stored value
ZERO_HARDWIRED, 1, 1 = register 0 reads 0, ignores writes, never busy

Ports:
system_clock  input  1  single clock, all state updates on rising edge
system_reset  input  1  synchronous, active-high reset
write_enable_0  input  1  write port 0 valid
write_address_0  input  ADDRESS_SIZE  write port 0 target
write_data_0  input  DATA_WIDTH  write port 0 data
write_enable_1  input  1  write port 1 valid (higher priority)
write_address_1  input  ADDRESS_SIZE  write port 1 target
write_data_1  input  DATA_WIDTH  write port 1 data
issue_enable  input  1  mark issue_address busy
issue_address  input  ADDRESS_SIZE  destination of newly issued instruction
read_address  input  READ_PORTS*ADDRESS_SIZE  flattened; port k at [k*ADDRESS_SIZE +: ADDRESS_SIZE]
read_data  output  READ_PORTS*DATA_WIDTH  flattened; port k at [k*DATA_WIDTH +: DATA_WIDTH]
read_busy  output  READ_PORTS  busy bit of register addressed by port k (post-bypass)
busy_vector  output  REGISTER_COUNT  raw scoreboard state

Behaviour:
Reset (system_reset high at rising edge):
- All registers cleared to 0; all busy bits cleared.
- Writes and issues presented in the same cycle are discarded.
- After reset: busy_vector = 0; every read_data = 0 (through the read path); read_busy = 0.

Writes:
- Registered on the rising edge when the port's enable is high and system_reset is low.
- Both ports target the same address: port 1 data stored, port 0 dropped.
- ZERO_HARDWIRED=1: writes to address 0 are ignored.

Reads:
- Combinational, zero latency.
- Address 0 with ZERO_HARDWIRED=1: data 0, busy 0, regardless of bypass.
- BYPASS_ENABLE=1 and address matches an enabled write port: returns that port's write_data in the same cycle (port 1 over port 0), otherwise the stored value.
- BYPASS_ENABLE=0: stored value only; new data visible the cycle after the write.
- Bypass is suppressed while system_reset is high; read_data then shows stored contents.

Scoreboard, per register r, next state:
- Set if issue_enable && issue_address==r.
- Else cleared if any enabled write port targets r.
- Else held.
- Issue wins over a same-cycle writeback to the same register (new producer outstanding).
- Issue to register 0 is ignored when ZERO_HARDWIRED=1.
- read_busy[k] = busy[addr_k], except forced 0 when BYPASS_ENABLE=1 and an enabled write port targets addr_k in the current cycle (data is being forwarded). This forcing applies even if an issue to addr_k occurs the same cycle; the set is visible next cycle.

Widths:
- No arithmetic.
- Addresses >= REGISTER_COUNT are impossible (power-of-two count).

Test Plan:
1. Reset, then read ports 0/1 at addresses 5/31 -> read_data 0, read_busy 0, busy_vector 0.
2. Write 0xDEADBEEF to r7 via port 0 while reading r7 -> same cycle read_data 0xDEADBEEF (BYPASS=1); with BYPASS=0, reads 0 that cycle and 0xDEADBEEF the next.
3. Same cycle: port 0 writes 0x11 to r3, port 1 writes 0x22 to r3 -> bypass returns 0x22; next cycle stored value 0x22.
4. Write 0x55 to r0, issue r0 -> read r0 gives 0, busy_vector[0] stays 0.
5. Issue r9; next cycle read_busy=1 for r9. Write r9 = 0xA5 -> read_busy 0 and data 0xA5 that cycle; busy_vector[9] = 0 next cycle. Then issue r9 and write r9 in the same cycle -> busy_vector[9] = 1 next cycle.
6. Write r4 = 0x1234 and issue r4, then assert system_reset together with write r4 = 0xFFFF -> next cycle r4 reads 0, busy_vector = 0.
